// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
// Holds the buffered {pc, instr} entry type, the fetch word size and the
// width helper for occupancy/credit counters (enough bits to hold DEPTH).
package fetch_pkg;

   localparam int WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Counters must represent 0..DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: in-order DEPTH-entry buffer of fetched {pc, instr} words.
// Latency: a push at edge t is visible at rd_dat after edge t; head is read from storage registers.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle; flush wins over push/pop.
// Ports: push/wr_dat write side, pop/rd_dat read side, flush clears all, count = occupancy, not_empty = head valid.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           push,
   input  fetch_entry_t                   wr_dat,
   input  logic                           pop,
   output fetch_entry_t                   rd_dat,
   output logic                           not_empty,
   output logic [cnt_width(DEPTH)-1:0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;
   logic          do_push;

   always_comb begin
      do_pop  = pop & (count_q != '0) & ~flush;
      do_push = push & ~flush & ((count_q != FULL) | do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_dat;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign rd_dat    = mem_q[rd_ptr_q];
   assign not_empty = (count_q != '0);
   assign count     = count_q;

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Purpose: sequential instruction prefetcher between a multi-cycle imem and decode, with redirect flush.
// Latency: response at edge t visible at instr_* after edge t; first request after a redirect valid the next cycle.
// Backpressure: requests issue only while buffer room covers every kept in-flight word; a request holds until accepted.
// Ports: redirect/redirect_pc (restart fetch), mem_req_* (valid/ready request), mem_rsp_* (in-order responses),
//        instr_* (valid/ready head entry). Optional macro PREFETCH_STATS_EN adds stat_fetched/stat_dropped.
module imem_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_data
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_dropped
`endif
);

   localparam int CW  = cnt_width(DEPTH);
   localparam int CW1 = CW + 1;
   localparam logic [CW-1:0]  MAX_OS  = CW'(MAX_OUTSTANDING);
   localparam logic [CW1-1:0] DEPTH_W = CW1'(DEPTH);
   localparam logic [31:0]    STEP    = 32'(WORD_BYTES);

   logic [31:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   pc_next_rsp_q, pc_next_rsp_d;
   logic [31:0]   stale_addr_q, stale_addr_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic          hold_q, hold_d;
   logic          stale_q, stale_d;
   logic          run_q;

   logic [CW-1:0] fifo_count;
   logic          acc, pend, issue_ok, drop_now, keep, pop;
   logic [31:0]   target;
   fetch_entry_t  push_entry, head;

   always_comb begin
      target = redirect_pc & ~32'h3;

      // Kept in-flight words are outstanding minus those already marked for drop;
      // compared as outstanding + count < DEPTH + drop so a pending stale request
      // (counted in drop but not yet in outstanding) cannot underflow.
      issue_ok = run_q & ~redirect & (outstanding_q < MAX_OS) &
                 (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (DEPTH_W + {1'b0, drop_cnt_q}));

      mem_req_valid = hold_q | issue_ok;
      // A request orphaned by a redirect keeps its old address until accepted.
      mem_req_addr  = stale_q ? stale_addr_q : fetch_addr_q;

      acc  = mem_req_valid & mem_req_ready;
      pend = mem_req_valid & ~mem_req_ready;

      drop_now = mem_rsp_valid & (redirect | (drop_cnt_q != '0));
      keep     = mem_rsp_valid & ~drop_now;
      pop      = instr_valid & instr_ready & ~redirect;

      outstanding_d = outstanding_q + CW'(acc) - CW'(mem_rsp_valid);
      hold_d        = pend;
      stale_d       = pend & (redirect | stale_q);
      stale_addr_d  = (redirect & pend) ? mem_req_addr : stale_addr_q;

      fetch_addr_d = fetch_addr_q;
      if (redirect) begin
         fetch_addr_d = target;
      end else if (acc & ~stale_q) begin
         fetch_addr_d = fetch_addr_q + STEP;
      end

      pc_next_rsp_d = pc_next_rsp_q;
      if (redirect) begin
         pc_next_rsp_d = target;
      end else if (keep) begin
         pc_next_rsp_d = pc_next_rsp_q + STEP;
      end

      drop_cnt_d = drop_cnt_q;
      if (redirect) begin
         // Everything still in flight after this edge belongs to the old stream.
         drop_cnt_d = outstanding_d + CW'(pend);
      end else if (mem_rsp_valid & (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end

      push_entry = '{pc: pc_next_rsp_q, instr: mem_rsp_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_addr_q  <= RESET_PC;
         pc_next_rsp_q <= RESET_PC;
         stale_addr_q  <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         hold_q        <= 1'b0;
         stale_q       <= 1'b0;
         run_q         <= 1'b0;
      end else begin
         fetch_addr_q  <= fetch_addr_d;
         pc_next_rsp_q <= pc_next_rsp_d;
         stale_addr_q  <= stale_addr_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         hold_q        <= hold_d;
         stale_q       <= stale_d;
         run_q         <= 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (keep),
      .wr_dat    (push_entry),
      .pop       (pop),
      .rd_dat    (head),
      .not_empty (instr_valid),
      .count     (fifo_count)
   );

   assign instr_pc   = head.pc;
   assign instr_data = head.instr;

`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_dropped_q, stat_dropped_d;
   logic [32:0] fetched_sum, dropped_sum;

   always_comb begin
      fetched_sum    = {1'b0, stat_fetched_q} + 33'(keep);
      dropped_sum    = {1'b0, stat_dropped_q} + 33'(drop_now) +
                       (redirect ? 33'(fifo_count) : 33'd0);
      stat_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      stat_dropped_d = dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_q <= '0;
         stat_dropped_q <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_dropped_q <= stat_dropped_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Bench for imem_prefetch_buffer: in-order memory model with configurable latency,
// expected-stream scoreboard rebuilt on every redirect/reset, request-hold checker.
module tb_imem_prefetch_buffer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;
`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_dropped;
`endif

   always #5 clk = ~clk;

   imem_prefetch_buffer #(
      .DEPTH (4), .MAX_OUTSTANDING (2), .RESET_PC (RESET_PC)
   ) dut (
      .clk (clk), .rst_n (rst_n), .redirect (redirect), .redirect_pc (redirect_pc),
      .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready), .mem_req_addr (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid), .mem_rsp_data (mem_rsp_data),
      .instr_valid (instr_valid), .instr_ready (instr_ready),
      .instr_pc (instr_pc), .instr_data (instr_data)
`ifdef PREFETCH_STATS_EN
      , .stat_fetched (stat_fetched), .stat_dropped (stat_dropped)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A3C_96E1;
   endfunction

   // ---------------- scoreboard: expected architectural fetch stream ----------------
   typedef struct { logic [31:0] pc; logic [31:0] dat; } ex_t;
   ex_t exp_q[$];
   ex_t mon_e;
   int  n_out = 0;
   logic [31:0] last_pc = '0;

   task automatic restart(input logic [31:0] t);
      logic [31:0] base;
      base = t & ~32'h3;
      exp_q.delete();
      for (int k = 0; k < 512; k++) begin
         exp_q.push_back('{pc: base + 32'(4 * k), dat: word_of(base + 32'(4 * k))});
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_extra actual pc=%h required=none", instr_pc);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_entry", {instr_pc, instr_data}, {mon_e.pc, mon_e.dat});
         end
         n_out++;
         last_pc = instr_pc;
      end
   end

   // ---------------- request sampling and hold-stability checker ----------------
   logic        acc_s = 1'b0;
   logic [31:0] acc_a = '0;
   logic [31:0] acc_log[$];
   logic        pv_rst = 1'b0, pv_vld = 1'b0, pv_rdy = 1'b0;
   logic [31:0] pv_addr = '0;

   always @(negedge clk) begin
      acc_s = rst_n && mem_req_valid && mem_req_ready;
      acc_a = mem_req_addr;
      if (acc_s) acc_log.push_back(mem_req_addr);
      if (rst_n && pv_rst && pv_vld && !pv_rdy)
         check("req_hold", {31'b0, mem_req_valid, mem_req_addr}, {32'd1, pv_addr});
      pv_rst = rst_n; pv_vld = mem_req_valid; pv_rdy = mem_req_ready; pv_addr = mem_req_addr;
   end

   // ---------------- memory model: in-order, latency lat_min..lat_max ----------------
   typedef struct { logic [31:0] a; int unsigned due; } mreq_t;
   mreq_t       pq[$];
   int unsigned cyc = 0;
   int          lat_min = 0, lat_max = 0, rdy_mode = 1;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (!rst_n) begin
            pq.delete();
            mem_rsp_valid = 1'b0;
         end else begin
            if (mem_rsp_valid) pq.delete(0);
            if (acc_s) pq.push_back('{a: acc_a, due: cyc + $urandom_range(lat_min, lat_max)});
            mem_rsp_valid = (pq.size() > 0) && (pq[0].due <= cyc);
            mem_rsp_data  = mem_rsp_valid ? word_of(pq[0].a) : $urandom();
         end
         case (rdy_mode)
            1:       mem_req_ready = 1'b1;
            2:       mem_req_ready = 1'b0;
            default: mem_req_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect = 1'b1; redirect_pc = t; restart(t);
      tick();
      redirect = 1'b0;
   endtask

   task automatic wait_first(input string name, input logic [31:0] exp_pc);
      int  n0;
      bit  got;
      n0 = n_out; got = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (n_out != n0) begin got = 1; break; end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s actual=timeout required=pc %h", name, exp_pc);
      end else begin
         check(name, last_pc, exp_pc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"},   mem_req_valid, 0);
      check({tag, "_instr_valid"}, instr_valid, 0);
      check({tag, "_instr_pc"},    instr_pc, 0);
      check({tag, "_instr_data"},  instr_data, 0);
`ifdef PREFETCH_STATS_EN
      check({tag, "_stats"}, {stat_fetched, stat_dropped}, 64'h0);
`endif
   endtask

   initial begin
      int v, n0, alen;
      logic [31:0] a_hold, t;

      #1 rst_n = 1'b0;
      #2 check_reset_outputs("rst0");
      repeat (3) tick();
      restart(RESET_PC);
      rst_n = 1'b1;

      // zero-wait memory, core always ready: one entry per cycle in steady state
      rdy_mode = 1; lat_min = 0; lat_max = 0;
      instr_ready = 1'b1;
      repeat (10) tick();
      v = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (instr_valid) v++;
      end
      check("stream_rate", v, 20);
      tick();

      // core stalls: buffer fills to DEPTH, then no more requests
      instr_ready = 1'b0;
      repeat (20) tick();
      v = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_req_valid) v++;
      end
      check("full_no_req", v, 0);
      check("full_head_pc", instr_pc, exp_q[0].pc);
      tick();
      rdy_mode = 2;
      n0 = n_out;
      instr_ready = 1'b1;
      repeat (12) tick();
      check("drain_count", n_out - n0, 4);

      // request held by memory (ready=0), redirect in its 2nd cycle
      a_hold = mem_req_addr;
      tick();
      do_redirect(32'h0000_0100);
      tick(); tick();
      check("hold_addr", {31'b0, mem_req_valid, mem_req_addr}, {32'd1, a_hold});
      alen = acc_log.size();
      rdy_mode = 1;
      wait_first("hold_first_pc", 32'h0000_0100);
      if (acc_log.size() >= alen + 2) begin
         check("stale_acc_addr", acc_log[alen], a_hold);
         check("next_acc_addr", acc_log[alen + 1], 32'h0000_0100);
      end else begin
         total++; bad++;
         $display("FAIL acc_count actual=%0d required>=%0d", acc_log.size(), alen + 2);
      end

      // two outstanding requests in flight, redirect to an unaligned target
      lat_min = 3; lat_max = 3;
      repeat (10) tick();
      do_redirect(32'h0000_0103);
      wait_first("unaligned_first_pc", 32'h0000_0100);

      // back-to-back redirects: only the last target survives
      lat_min = 0; lat_max = 1;
      redirect = 1'b1; redirect_pc = 32'h40; restart(32'h40); tick();
      redirect_pc = 32'h80; restart(32'h80); tick();
      redirect_pc = 32'hC0; restart(32'hC0); tick();
      redirect = 1'b0;
      wait_first("b2b_first_pc", 32'h0000_00C0);

      // address wrap at the top of the space
      lat_min = 0; lat_max = 0;
      do_redirect(32'hFFFF_FFF6);
      n0 = n_out;
      repeat (20) tick();
      check("wrap_progress", (n_out - n0) >= 5, 1);

      // random traffic with random redirects
      rdy_mode = 0; lat_min = 0; lat_max = 3;
      n0 = n_out;
      for (int i = 0; i < 400; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom();
            redirect = 1'b1; redirect_pc = t; restart(t);
         end else begin
            redirect = 1'b0;
         end
         tick();
      end
      redirect = 1'b0;
      check("random_progress", (n_out - n0) > 50, 1);

      // asynchronous reset mid-stream with words buffered and in flight
      rdy_mode = 1; lat_min = 3; lat_max = 3; instr_ready = 1'b1;
      repeat (10) tick();
      instr_ready = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1 check_reset_outputs("rst_mid");
      repeat (3) tick();
      restart(RESET_PC);
      alen = acc_log.size();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      wait_first("post_reset_first_pc", RESET_PC);
      if (acc_log.size() > alen) check("post_reset_addr", acc_log[alen], RESET_PC);
      else begin
         total++; bad++;
         $display("FAIL post_reset_addr actual=none required=%h", RESET_PC);
      end
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/imem_prefetch_buffer.md
Name: imem_prefetch_buffer

Overview:
Instruction fetch front-end between a multi-cycle instruction memory and the core decode stage. Issues sequential word fetches ahead of the core and buffers returned words with their PC in an in-order FIFO. Presents one {pc, instruction} entry per cycle to the core. Discards all stale buffered and in-flight words on a control-flow redirect (taken branch or jump).

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests, 1..DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
redirect  input  1  core requests a fetch restart
redirect_pc  input  32  new fetch address; bits[1:0] ignored and forced to 0
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  word-aligned fetch address
mem_rsp_valid  input  1  response word valid; responses return in request order
mem_rsp_data  input  32  instruction word
instr_valid  output  1  head entry available
instr_ready  input  1  core consumes head entry
instr_pc  output  32  PC of head entry
instr_data  output  32  instruction of head entry

Behaviour:
- Reset, asynchronous: fetch_addr=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0. Outputs mem_req_valid=0, instr_valid=0, instr_pc=0, instr_data=0. The memory side is reset by the same rst_n; no response arrives for a pre-reset request.
- Issue condition: (outstanding < MAX_OUTSTANDING) and (outstanding - drop_cnt + fifo_count < DEPTH) and no redirect this cycle. The FIFO therefore never overflows; no full-drop path exists.
- Request handshake: once mem_req_valid=1, valid and addr hold until mem_req_ready=1. On accept: outstanding+1, fetch_addr+=4. fetch_addr wraps 32'hFFFF_FFFC to 0.
- Redirect with an unaccepted request pending: the request keeps its address until it is accepted and is counted as droppable.
- Response: outstanding-1. If drop_cnt>0, the word is discarded and drop_cnt-1. Otherwise it is pushed as {pc of that request, data}; a per-entry PC is tracked by a pc_next_rsp register advanced by 4 on each kept response.
- Output: instr_valid = fifo not empty; instr_pc and instr_data come from the registered head. Pop on instr_valid & instr_ready. Push and pop in the same cycle are allowed at any count.
- Latency: a response at edge t is visible at instr_* after edge t. A redirect at edge t flushes the FIFO. The first new request is valid in cycle t+1. Best case: the first new instruction is presented 2 cycles after the redirect with zero-wait memory.
- Redirect cycle: the FIFO is cleared, a pop in that cycle is ignored, and fetch_addr and pc_next_rsp are set to {redirect_pc[31:2],2'b00}. drop_cnt becomes outstanding, adjusted for any accept and response in the same cycle, plus 1 if a request is still pending unaccepted. A response in the redirect cycle is discarded.
- Back-to-back redirects: each redirect recomputes drop_cnt from current in-flight state; only the last redirect target survives.
- Empty FIFO with instr_ready=1: no effect.

Optional Feature:
PREFETCH_STATS_EN: when defined, adds output ports stat_fetched[31:0] (kept responses) and stat_dropped[31:0] (discarded responses plus flushed FIFO entries). Both counters reset to 0 and saturate at 32'hFFFF_FFFF. When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds: the fetch_entry_t struct {pc[31:0], instr[31:0]}, WORD_BYTES=4, and the localparam width helper for counters ($clog2(DEPTH)+1).
- One natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count and registered head. The credit and drop logic stays in the top level.

Test Plan:
- Reset release, zero-wait memory (ready=1, response 1 cycle after accept), instr_ready=1 -> stream pc 0x0,0x4,0x8... with matching words; one entry per cycle in steady state.
- instr_ready=0 held -> exactly DEPTH=4 entries buffered (pc 0x0-0xC); no further mem_req_valid; release -> in-order drain with no loss.
- Two requests outstanding (0x8, 0xC), redirect to 0x103 -> both responses dropped; next output pc=0x100.
- mem_req_ready=0 for 5 cycles with redirect in cycle 2 -> addr held stable at the old value; on accept, the response is dropped; the following request addr=0x100.
- Redirect in 3 consecutive cycles to 0x40, 0x80, 0xC0 -> first output pc=0xC0; no 0x40/0x80 entries appear.
- rst_n asserted mid-stream with 2 outstanding and 3 buffered -> all outputs 0 immediately; after release, fetch restarts at RESET_PC; with PREFETCH_STATS_EN, both counters read 0.
